// File: rtl/axicb_cpl_tracker.sv
// axicb_cpl_tracker: per-master completion ordering tracker for the crossbar switch.
// Hashed ID slots with FIFOs, round-robin completion arbitration, DECERR bursts.
module axicb_cpl_tracker #(
    parameter int                  RD_PATH     = 0,
    parameter int                  AXI_ID_W    = 8,
    parameter int                  SLV_NB      = 4,
    parameter int                  ID_NB       = 4,
    parameter int                  ID_DEPTH    = 4,
    parameter logic [AXI_ID_W-1:0] MST_ID_MASK = '0,
    parameter int                  CCH_W       = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    a_valid,
    input  logic                    a_ready,
    output logic                    a_full,
    input  logic [7:0]              a_len,
    input  logic [AXI_ID_W-1:0]     a_id,
    input  logic [SLV_NB-1:0]       a_ix,
    input  logic                    a_mr,
    input  logic [SLV_NB-1:0]       c_valid,
    input  logic [SLV_NB-1:0]       c_last,
    input  logic [CCH_W*SLV_NB-1:0] c_ch,
    input  logic                    c_ready,
    output logic [SLV_NB-1:0]       c_grant,
    output logic                    c_mr,
    output logic [7:0]              c_len,
    output logic [AXI_ID_W-1:0]     c_id,
    output logic                    c_mr_last,
    output logic                    busy,
    output logic                    err_unexp,
    output logic                    err_ovf
);

    localparam int IX_W = $clog2(ID_NB);
    localparam int PT_W = $clog2(ID_DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t state;
    state_t state_nxt;

    logic [7:0]          st_len [ID_NB][ID_DEPTH];
    logic [SLV_NB-1:0]   st_ix  [ID_NB][ID_DEPTH];
    logic                st_mr  [ID_NB][ID_DEPTH];
    logic [AXI_ID_W-1:0] st_id  [ID_NB][ID_DEPTH];

    logic [PT_W-1:0] wr_ptr [ID_NB];
    logic [PT_W-1:0] rd_ptr [ID_NB];
    logic [PT_W:0]   used   [ID_NB];

    logic [ID_NB-1:0]    h_vld;
    logic [ID_NB-1:0]    h_mr;
    logic [ID_NB-1:0]    full;
    logic [SLV_NB-1:0]   h_ix  [ID_NB];
    logic [7:0]          h_len [ID_NB];
    logic [AXI_ID_W-1:0] h_id  [ID_NB];

    logic            push_en;
    logic [IX_W-1:0] push_slot;
    logic [ID_NB-1:0] psh;
    logic [ID_NB-1:0] pll;
    logic [ID_NB-1:0] acc;

    logic [ID_NB-1:0] req_mr;
    logic [ID_NB-1:0] req_nm;
    logic [ID_NB-1:0] req_sel;
    logic             unexp;
    logic             win_vld;
    logic [IX_W-1:0]  win;
    logic [IX_W-1:0]  lock;
    logic [IX_W-1:0]  rr_ptr;
    logic [7:0]       cnt;
    logic             beat;
    logic             fin;
    logic             mr_last;

    function automatic logic [IX_W-1:0] slot_of(input logic [AXI_ID_W-1:0] id);
        logic [AXI_ID_W-1:0] h;
        h = id ^ MST_ID_MASK;
        return h[IX_W-1:0];
    endfunction

    always_comb begin
        for (int i = 0; i < ID_NB; i++) begin
            h_vld[i] = (used[i] != '0);
            full[i]  = (used[i] == (PT_W+1)'(ID_DEPTH));
            h_ix[i]  = st_ix[i][rd_ptr[i]];
            h_mr[i]  = st_mr[i][rd_ptr[i]];
            h_len[i] = st_len[i][rd_ptr[i]];
            h_id[i]  = st_id[i][rd_ptr[i]];
        end
    end

    assign push_en   = a_valid & a_ready;
    assign push_slot = slot_of(a_id);

    // A full slot still accepts a push when its head retires in the same cycle.
    always_comb begin
        for (int i = 0; i < ID_NB; i++) begin
            psh[i] = push_en && (push_slot == IX_W'(i));
            pll[i] = fin && (lock == IX_W'(i));
            acc[i] = psh[i] && (!full[i] || pll[i]);
        end
    end

    always_comb begin
        logic [IX_W-1:0] k;
        k      = '0;
        req_nm = '0;
        unexp  = 1'b0;
        for (int i = 0; i < ID_NB; i++) begin
            req_mr[i] = h_vld[i] & h_mr[i];
        end
        for (int j = 0; j < SLV_NB; j++) begin
            if (c_valid[j]) begin
                k = slot_of(c_ch[j*CCH_W +: AXI_ID_W]);
                if (h_vld[k] && h_ix[k][j]) begin
                    if (!h_mr[k]) begin
                        req_nm[k] = 1'b1;
                    end
                end else begin
                    unexp = 1'b1;
                end
            end
        end
    end

    // Misrouted heads win outright; rotate within the winning class.
    always_comb begin
        logic [IX_W-1:0] idx;
        idx     = '0;
        req_sel = (|req_mr) ? req_mr : req_nm;
        win_vld = 1'b0;
        win     = '0;
        for (int n = 0; n < ID_NB; n++) begin
            idx = rr_ptr + IX_W'(n);
            if (!win_vld && req_sel[idx]) begin
                win_vld = 1'b1;
                win     = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        beat      = 1'b0;
        fin       = 1'b0;
        mr_last   = 1'b0;
        unique case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (h_mr[lock]) begin
                    mr_last = (RD_PATH != 0) ? (cnt == h_len[lock]) : 1'b1;
                    beat    = c_ready;
                    fin     = beat & mr_last;
                end else begin
                    beat = (|(c_valid & h_ix[lock])) & c_ready;
                    fin  = beat & ((RD_PATH != 0) ? |(c_last & h_ix[lock]) : 1'b1);
                end
                if (fin) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        for (int i = 0; i < ID_NB; i++) begin
            if (acc[i]) begin
                st_len[i][wr_ptr[i]] <= (RD_PATH != 0) ? a_len : 8'd0;
                st_ix[i][wr_ptr[i]]  <= a_ix;
                st_mr[i][wr_ptr[i]]  <= a_mr;
                st_id[i][wr_ptr[i]]  <= a_id;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= IDLE;
            lock      <= '0;
            rr_ptr    <= '0;
            cnt       <= '0;
            err_unexp <= 1'b0;
            err_ovf   <= 1'b0;
            for (int i = 0; i < ID_NB; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                used[i]   <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == IDLE && win_vld) begin
                lock <= win;
            end
            if (fin) begin
                rr_ptr <= lock + IX_W'(1);
                cnt    <= '0;
            end else if (beat && h_mr[lock]) begin
                cnt <= cnt + 8'd1;
            end
            if (state == IDLE && unexp) begin
                err_unexp <= 1'b1;
            end
            if (|(psh & full & ~pll)) begin
                err_ovf <= 1'b1;
            end
            for (int i = 0; i < ID_NB; i++) begin
                if (acc[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PT_W'(1);
                end
                if (pll[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PT_W'(1);
                end
                if (acc[i] && !pll[i]) begin
                    used[i] <= used[i] + (PT_W+1)'(1);
                end else if (!acc[i] && pll[i]) begin
                    used[i] <= used[i] - (PT_W+1)'(1);
                end
            end
        end
    end

    assign busy      = (state == BUSY);
    assign a_full    = |full;
    assign c_mr      = busy & h_mr[lock];
    assign c_grant   = (busy && !h_mr[lock]) ? h_ix[lock] : '0;
    assign c_len     = busy ? h_len[lock] : 8'd0;
    assign c_id      = busy ? h_id[lock] : '0;
    assign c_mr_last = c_mr & mr_last;

endmodule

// File: tb/tb_axicb_cpl_tracker.sv
// Bench for axicb_cpl_tracker: directed scenarios then random traffic,
// every cycle compared against a queue-based reference model.
module tb_axicb_cpl_tracker;

    localparam int ID_NB    = 4;
    localparam int ID_DEPTH = 4;
    localparam int SLV_NB   = 4;
    localparam int MASK     = 0;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        a_valid;
    logic        a_ready;
    logic        a_full;
    logic [7:0]  a_len;
    logic [7:0]  a_id;
    logic [3:0]  a_ix;
    logic        a_mr;
    logic [3:0]  c_valid;
    logic [3:0]  c_last;
    logic [31:0] c_ch;
    logic        c_ready;
    logic [3:0]  c_grant;
    logic        c_mr;
    logic [7:0]  c_len;
    logic [7:0]  c_id;
    logic        c_mr_last;
    logic        busy;
    logic        err_unexp;
    logic        err_ovf;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int len;
        int ix;
        bit mr;
        int id;
    } ent_t;

    ent_t q [ID_NB][$];
    bit   m_busy;
    int   m_slot;
    int   m_beats;
    int   m_rr;
    bit   m_unexp;
    bit   m_ovf;

    axicb_cpl_tracker #(
        .RD_PATH(1), .AXI_ID_W(8), .SLV_NB(SLV_NB), .ID_NB(ID_NB),
        .ID_DEPTH(ID_DEPTH), .MST_ID_MASK(8'(MASK)), .CCH_W(8)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .a_valid(a_valid), .a_ready(a_ready), .a_full(a_full),
        .a_len(a_len), .a_id(a_id), .a_ix(a_ix), .a_mr(a_mr),
        .c_valid(c_valid), .c_last(c_last), .c_ch(c_ch), .c_ready(c_ready),
        .c_grant(c_grant), .c_mr(c_mr), .c_len(c_len), .c_id(c_id),
        .c_mr_last(c_mr_last), .busy(busy),
        .err_unexp(err_unexp), .err_ovf(err_ovf)
    );

    always #5 aclk = ~aclk;

    function automatic int slot_of(input int id);
        return (id ^ MASK) % ID_NB;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: what the tracker does at the coming rising edge.
    task automatic model_edge();
        bit   pull;
        bit   do_push;
        int   g;
        int   s;
        int   k;
        int   win;
        bit   any_m;
        ent_t h;
        ent_t e;
        bit   nreq [ID_NB];
        bit   mreq [ID_NB];
        if (!aresetn) begin
            foreach (q[i]) q[i].delete();
            m_busy = 0; m_slot = 0; m_beats = 0; m_rr = 0;
            m_unexp = 0; m_ovf = 0;
            return;
        end
        pull = 0;
        do_push = 0;
        s = 0;
        e = '{len: 0, ix: 0, mr: 0, id: 0};
        if (m_busy) begin
            h = q[m_slot][0];
            if (h.mr) begin
                if (c_ready) begin
                    if (m_beats == h.len) pull = 1;
                    else m_beats++;
                end
            end else begin
                g = 0;
                for (int j = 0; j < SLV_NB; j++) if (((h.ix >> j) & 1) != 0) g = j;
                if (c_valid[g] && c_ready && c_last[g]) pull = 1;
            end
        end else begin
            any_m = 0;
            for (int i = 0; i < ID_NB; i++) begin
                nreq[i] = 0;
                mreq[i] = (q[i].size() > 0) && q[i][0].mr;
                if (mreq[i]) any_m = 1;
            end
            for (int j = 0; j < SLV_NB; j++) begin
                if (c_valid[j]) begin
                    k = slot_of(int'(c_ch[j*8 +: 8]));
                    if (q[k].size() > 0 && ((q[k][0].ix >> j) & 1) != 0) begin
                        if (!q[k][0].mr) nreq[k] = 1;
                    end else begin
                        m_unexp = 1;
                    end
                end
            end
            win = -1;
            for (int n = 0; n < ID_NB; n++) begin
                k = (m_rr + n) % ID_NB;
                if (win < 0 && (any_m ? mreq[k] : nreq[k])) win = k;
            end
            if (win >= 0) begin
                m_busy = 1; m_slot = win; m_beats = 0;
            end
        end
        if (a_valid && a_ready) begin
            s = slot_of(int'(a_id));
            e = '{len: int'(a_len), ix: int'(a_ix), mr: a_mr, id: int'(a_id)};
            if (q[s].size() < ID_DEPTH || (pull && m_slot == s)) do_push = 1;
            else m_ovf = 1;
        end
        if (pull) begin
            void'(q[m_slot].pop_front());
            m_busy = 0;
            m_rr = (m_slot + 1) % ID_NB;
            m_beats = 0;
        end
        if (do_push) q[s].push_back(e);
    endtask

    task automatic check_all();
        ent_t h;
        int eg, elen, eid;
        bit emr, elast, ef;
        eg = 0; elen = 0; eid = 0; emr = 0; elast = 0; ef = 0;
        if (m_busy) begin
            h = q[m_slot][0];
            eg = h.mr ? 0 : h.ix;
            emr = h.mr;
            elen = h.len;
            eid = h.id;
            elast = h.mr && (m_beats == h.len);
        end
        for (int i = 0; i < ID_NB; i++) if (q[i].size() == ID_DEPTH) ef = 1;
        chk("m_busy", busy, m_busy);
        chk("m_grant", c_grant, eg);
        chk("m_mr", c_mr, emr);
        chk("m_len", c_len, elen);
        chk("m_id", c_id, eid);
        chk("m_mr_last", c_mr_last, elast);
        chk("m_full", a_full, ef);
        chk("m_unexp", err_unexp, m_unexp);
        chk("m_ovf", err_ovf, m_ovf);
    endtask

    task automatic step();
        model_edge();
        @(posedge aclk);
        #1;
        check_all();
    endtask

    task automatic clr_c();
        c_valid = '0;
        c_last = '0;
        c_ch = '0;
    endtask

    task automatic slv(input int j, input int id, input bit last);
        c_valid[j] = 1'b1;
        c_last[j] = last;
        c_ch[j*8 +: 8] = 8'(id);
    endtask

    task automatic push(input int id, input int len, input int ix, input bit mr);
        a_valid = 1; a_ready = 1;
        a_id = 8'(id); a_len = 8'(len); a_ix = 4'(ix); a_mr = mr;
        step();
        a_valid = 0;
    endtask

    initial begin
        logic [3:0] t2_seq [4];
        int n;
        t2_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
        aresetn = 0; a_valid = 0; a_ready = 0; a_len = 0; a_id = 0;
        a_ix = 0; a_mr = 0; c_ready = 0;
        clr_c();
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_full", a_full, 0);
        chk("rst_grant", c_grant, 0);
        aresetn = 1;

        // single read burst, 4 beats from slave 1
        push(2, 3, 4'b0010, 0);
        slv(1, 2, 0);
        c_ready = 1;
        step();
        chk("t1_grant", c_grant, 4'b0010);
        for (int b = 1; b <= 4; b++) begin
            if (b == 4) c_last[1] = 1;
            step();
            if (b < 4) chk("t1_hold", c_grant, 4'b0010);
        end
        clr_c();
        chk("t1_busy_off", busy, 0);
        step();
        chk("t1_idle", c_grant, 0);

        // round-robin between slots 0 and 1
        push(0, 0, 4'b0001, 0);
        push(1, 0, 4'b0010, 0);
        push(0, 0, 4'b0001, 0);
        push(1, 0, 4'b0010, 0);
        slv(0, 0, 1);
        slv(1, 1, 1);
        for (int r = 0; r < 4; r++) begin
            step();
            chk("t2_order", c_grant, t2_seq[r]);
            step();
            chk("t2_gap", busy, 0);
            if (r == 2) c_valid[0] = 0;
        end
        clr_c();
        chk("t2_no_unexp", err_unexp, 0);

        // misrouted burst beats a pending normal completion
        push(0, 0, 4'b0001, 0);
        push(3, 2, 4'b0000, 1);
        slv(0, 0, 1);
        step();
        chk("t3_mr", c_mr, 1);
        chk("t3_grant0", c_grant, 0);
        chk("t3_last_b1", c_mr_last, 0);
        step();
        chk("t3_last_b2", c_mr_last, 0);
        step();
        chk("t3_last_b3", c_mr_last, 1);
        step();
        chk("t3_gap", busy, 0);
        step();
        chk("t3_normal", c_grant, 4'b0001);
        step();
        clr_c();

        // unexpected completion on slave 2
        chk("t5_pre", err_unexp, 0);
        slv(2, 0, 0);
        step();
        chk("t5_unexp", err_unexp, 1);
        chk("t5_busy", busy, 0);
        clr_c();
        step();
        chk("t5_grant", c_grant, 0);

        // overflow of slot 1 and push during pull
        push(1, 0, 4'b0100, 0);
        push(5, 1, 4'b0100, 0);
        push(9, 0, 4'b0100, 0);
        push(13, 0, 4'b0100, 0);
        chk("t4_full", a_full, 1);
        chk("t4_ovf0", err_ovf, 0);
        push(17, 0, 4'b0100, 0);
        chk("t4_ovf1", err_ovf, 1);
        slv(2, 1, 1);
        step();
        chk("t4_grant", c_grant, 4'b0100);
        chk("t4_head", c_id, 1);
        a_valid = 1; a_ready = 1; a_id = 21; a_len = 0; a_ix = 4'b0100; a_mr = 0;
        step();
        a_valid = 0;
        chk("t4_full_kept", a_full, 1);
        n = 0;
        while (q[1].size() > 0 && n < 40) begin
            step();
            n++;
        end
        clr_c();
        chk("t4_drain_bound", n < 40, 1);
        step();
        chk("t4_empty", a_full, 0);

        // reset in the middle of a burst
        push(2, 3, 4'b0010, 0);
        slv(1, 2, 0);
        step();
        step();
        aresetn = 0;
        step();
        chk("t6_busy", busy, 0);
        chk("t6_grant", c_grant, 0);
        chk("t6_full", a_full, 0);
        chk("t6_id", c_id, 0);
        chk("t6_len", c_len, 0);
        chk("t6_ovf", err_ovf, 0);
        chk("t6_unexp", err_unexp, 0);
        aresetn = 1;
        clr_c();
        push(2, 3, 4'b0010, 0);
        slv(1, 2, 1);
        step();
        chk("t6_regrant", c_grant, 4'b0010);
        step();
        clr_c();
        step();
        chk("t6_done", busy, 0);

        // longest misrouted burst: 256 beats
        push(6, 255, 4'b0000, 1);
        step();
        n = 0;
        while (!c_mr_last && n < 300) begin
            step();
            n++;
        end
        chk("t7_beats", n, 255);
        step();
        chk("t7_end", busy, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            aresetn = ($urandom % 700) != 0;
            a_valid = ($urandom % 100) < 30;
            if (a_full && ($urandom % 4) != 0) a_valid = 0;
            a_ready = ($urandom % 100) < 85;
            a_id = 8'($urandom);
            a_len = (($urandom % 8) == 0) ? 8'($urandom % 16) : 8'($urandom % 3);
            a_ix = 4'(1 << ($urandom % 4));
            a_mr = ($urandom % 100) < 12;
            for (int j = 0; j < SLV_NB; j++) begin
                c_valid[j] = ($urandom % 100) < 40;
                c_last[j] = ($urandom % 2) != 0;
            end
            c_ch = $urandom;
            c_ready = ($urandom % 100) < 70;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
